seq_mul_div_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/seq_mul_div_unit.sv | 161 ++++++++++++++++
 tb/tb_seq_mul_div_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_div_unit.sv
// rtl/seq_mul_div_unit.sv - multi-cycle signed/unsigned multiply/divide unit with HI/LO registers
module seq_mul_div_unit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   F,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] Y,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIX} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d, dz_q, dz_d, zero_q, zero_d;
    logic           is_div_q, is_div_d, is_sgn_q, is_sgn_d;
    logic           neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     sum, shifted, diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            zero_q    <= 1'b0;
            is_div_q  <= 1'b0;
            is_sgn_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            zero_q    <= zero_d;
            is_div_q  <= is_div_d;
            is_sgn_q  <= is_sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        zero_d    = zero_q;
        is_div_d  = is_div_q;
        is_sgn_d  = is_sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        a_mag     = '0;
        b_mag     = '0;
        sum       = '0;
        shifted   = '0;
        diff      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (F)
                        4'd1: hi_d = A;
                        4'd3: lo_d = A;
                        4'd8, 4'd9, 4'd10, 4'd11: begin
                            // Operands are latched here so the caller may change them after acceptance
                            a_d      = A;
                            b_d      = B;
                            is_div_d = F[1];
                            is_sgn_d = ~F[0];
                            dz_d     = 1'b0;
                            zero_d   = F[1] && (B == '0);
                            state_d  = (F[1] && (B == '0)) ? S_FIX : S_LOAD;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                a_mag     = (is_sgn_q && a_q[N-1]) ? -a_q : a_q;
                b_mag     = (is_sgn_q && b_q[N-1]) ? -b_q : b_q;
                neg_quo_d = is_sgn_q && (a_q[N-1] ^ b_q[N-1]);
                neg_rem_d = is_sgn_q && a_q[N-1];
                acc_d     = {{N{1'b0}}, (is_div_q ? a_mag : b_mag)};
                m_d       = is_div_q ? b_mag : a_mag;
                cnt_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // Divide keeps remainder in the upper half and quotient bits shift into the lower half
                if (is_div_q) begin
                    shifted = acc_q[2*N-1:N-1];
                    diff    = shifted - {1'b0, m_q};
                    if (!diff[N]) acc_d = {diff[N-1:0], acc_q[N-2:0], 1'b1};
                    else          acc_d = {acc_q[2*N-2:0], 1'b0};
                end else begin
                    sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? m_q : {N{1'b0}})};
                    acc_d = {sum, acc_q[N-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (zero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_quo_q ? -acc_q[N-1:0] : acc_q[N-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
                end else begin
                    {hi_d, lo_d} = neg_quo_q ? -acc_q : acc_q;
                end
                zero_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign Y        = F[1] ? lo_q : hi_q;
endmodule

// File: tb/tb_seq_mul_div_unit.sv
// tb/tb_seq_mul_div_unit.sv - scoreboard bench for seq_mul_div_unit at N=4 and N=8
module tb_seq_mul_div_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] a4, b4, f4, y4, hi4, lo4, f8;
    logic       start4, busy4, done4, dz4;
    logic [7:0] a8, b8, y8, hi8, lo8;
    logic       start8, busy8, done8, dz8;

    int checks = 0;
    int failures = 0;
    int q4[$];
    int q8[$];
    int push8 = 0;
    int done_cnt8 = 0;
    int mexp4, mgot4, mexp8, mgot8;

    seq_mul_div_unit #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .F(f4), .start(start4),
        .busy(busy4), .done(done4), .div_zero(dz4), .Y(y4), .hi(hi4), .lo(lo4)
    );

    seq_mul_div_unit #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .F(f8), .start(start8),
        .busy(busy8), .done(done8), .div_zero(dz8), .Y(y8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected {div_zero, hi, lo} from plain integer arithmetic
    function automatic int ref_model(input int n, input int f, input int a, input int b);
        int mask, sa, sb, hi_v, lo_v, dz;
        longint p;
        mask = (1 << n) - 1;
        sa = a;
        sb = b;
        dz = 0;
        if (f == 8 || f == 10) begin
            if (a >= (1 << (n - 1))) sa = a - (1 << n);
            if (b >= (1 << (n - 1))) sb = b - (1 << n);
        end
        if (f == 8 || f == 9) begin
            p = longint'(sa) * longint'(sb);
            lo_v = int'(p) & mask;
            hi_v = int'(p >>> n) & mask;
        end else if (b == 0) begin
            hi_v = a;
            lo_v = mask;
            dz = 1;
        end else begin
            lo_v = (sa / sb) & mask;
            hi_v = (sa % sb) & mask;
        end
        return (dz << (2 * n)) | (hi_v << n) | lo_v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done4) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL mon4_unexpected_done got=done exp=no_done");
            end else begin
                mexp4 = q4.pop_front();
                mgot4 = int'({dz4, hi4, lo4});
                if (mgot4 != mexp4) begin
                    failures++;
                    $display("FAIL mon4_result got=%0h exp=%0h", mgot4, mexp4);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            done_cnt8++;
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL mon8_unexpected_done got=done exp=no_done");
            end else begin
                mexp8 = q8.pop_front();
                mgot8 = int'({dz8, hi8, lo8});
                if (mgot8 != mexp8) begin
                    failures++;
                    $display("FAIL mon8_result got=%0h exp=%0h", mgot8, mexp8);
                end
            end
        end
    end

    task automatic issue4(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b, input bit push);
        @(negedge clk);
        f4 = f; a4 = a; b4 = b; start4 = 1'b1;
        if (push) q4.push_back(ref_model(4, int'(f), int'(a), int'(b)));
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
    endtask

    task automatic wait_done4(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done4) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout got=no_done exp=done", name);
        end
    endtask

    task automatic run8(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        bit seen = 1'b0;
        @(negedge clk);
        f8 = f; a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back(ref_model(8, int'(f), int'(a), int'(b)));
        push8++;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        // Stray requests and operand churn while busy must be ignored
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                seen = 1'b1;
                start8 = 1'b0;
            end else begin
                start8 = 1'($urandom);
                f8 = 4'($urandom);
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL run8_timeout got=no_done exp=done");
        end
    endtask

    initial begin
        logic [3:0] rf;
        logic [7:0] ra, rb;
        rst_n = 1'b0;
        start4 = 1'b0; f4 = '0; a4 = '0; b4 = '0;
        start8 = 1'b0; f8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset4", 32'({hi4, lo4, busy4, done4, dz4}), 32'h0);
        check("reset8", 32'({hi8, lo8, busy8, done8, dz8}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue4(4'd9, 4'd7, 4'd5, 1'b1);
        check("t1_busy_e0", 32'({busy4, done4}), 32'h2);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t1_busy_e%0d", k), 32'({busy4, done4}), 32'h2);
        end
        @(posedge clk);
        #1;
        check("t1_done_e6", 32'({busy4, done4}), 32'h1);
        check("t1_multu", 32'({hi4, lo4}), 32'h23);

        issue4(4'd8, 4'hD, 4'd5, 1'b1);
        wait_done4("t2_mult");
        check("t2_mult", 32'({hi4, lo4}), 32'hF1);
        issue4(4'd10, 4'h9, 4'd2, 1'b1);
        wait_done4("t2_div");
        check("t2_div", 32'({hi4, lo4}), 32'hFD);

        issue4(4'd11, 4'd13, 4'd4, 1'b1);
        wait_done4("t3_divu");
        check("t3_divu", 32'({dz4, hi4, lo4}), 32'h013);
        issue4(4'd11, 4'd9, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        check("t3_dz_done", 32'(done4), 32'h1);
        check("t3_dz_result", 32'({dz4, hi4, lo4}), 32'h19F);

        issue4(4'd10, 4'h8, 4'hF, 1'b1);
        check("t4_dz_cleared", 32'(dz4), 32'h0);
        wait_done4("t4_div_ovf");
        check("t4_div_ovf", 32'({dz4, hi4, lo4}), 32'h008);
        issue4(4'd1, 4'd6, 4'd0, 1'b0);
        check("t4_mthi_nobusy", 32'(busy4), 32'h0);
        f4 = 4'd0;
        #1;
        check("t4_mfhi", 32'(y4), 32'h6);
        issue4(4'd3, 4'd2, 4'd0, 1'b0);
        f4 = 4'd2;
        #1;
        check("t4_mflo", 32'(y4), 32'h2);
        issue4(4'd5, 4'd9, 4'd9, 1'b0);
        check("t4_noop", 32'({busy4, hi4, lo4}), 32'h062);

        issue4(4'd9, 4'd3, 4'd3, 1'b1);
        @(posedge clk);
        #1;
        start4 = 1'b1; f4 = 4'd1; a4 = 4'hA;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done4("t5_ignore");
        check("t5_ignore", 32'({hi4, lo4}), 32'h09);
        issue4(4'd9, 4'd7, 4'd7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_reset", 32'({hi4, lo4, busy4, done4}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t5_no_result", 32'({hi4, lo4, busy4}), 32'h0);

        for (int i = 0; i < 300; i++) begin
            rf = 4'(8 + $urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                ra = 8'h80;
                rb = 8'hFF;
            end
            run8(rf, ra, rb);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        #1;
        check("done_count8", 32'(done_cnt8), 32'(push8));
        check("q4_drained", 32'(q4.size()), 32'h0);
        check("q8_drained", 32'(q8.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
